regfile_cc: RTL

REGFILE_CC -- requirements
Module: regfile_cc

---
 rtl/regfile_cc.sv | 84 ++++++++
 1 files changed

// File: rtl/regfile_cc.sv
// rtl/regfile_cc.sv - eight-entry register file with N/Z/P condition codes and branch enable
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   synchronous active-low reset
//   IR       in  16   instruction: DR/SR1 [11:9], SR1 [8:6], imm flag [5], imm5 [4:0], SR2 [2:0], nzp [11:9]
//   BUS      in  16   write data and condition-code source
//   LD_REG   in   1   write BUS into destination register
//   LD_CC    in   1   load N/Z/P from BUS
//   LD_BEN   in   1   load branch enable
//   DRMUX    in   1   destination: 0 = IR[11:9], 1 = R7
//   SR1MUX   in   1   source 1: 0 = IR[11:9], 1 = IR[8:6]
//   SR1_OUT  out 16   source-1 register contents
//   ALU_B    out 16   SEXT(imm5) when IR[5], else register IR[2:0]
//   SR2_OUT  out 16   register IR[2:0] contents
//   NZP      out  3   condition codes {N,Z,P}
//   BEN      out  1   registered branch enable

module regfile_cc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] IR,
    input  logic [15:0] BUS,
    input  logic        LD_REG,
    input  logic        LD_CC,
    input  logic        LD_BEN,
    input  logic        DRMUX,
    input  logic        SR1MUX,
    output logic [15:0] SR1_OUT,
    output logic [15:0] ALU_B,
    output logic [15:0] SR2_OUT,
    output logic [2:0]  NZP,
    output logic        BEN
);

    logic [15:0] regs [0:7];
    logic [2:0]  nzp_q;
    logic        ben_q;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  cc_next;

    // Opcode bits are decoded elsewhere; they do not affect this block.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, IR[15:12]};

    assign dr  = DRMUX  ? 3'd7     : IR[11:9];
    assign sr1 = SR1MUX ? IR[8:6]  : IR[11:9];

    // Reads see register state only: a same-cycle write is visible next cycle.
    assign SR1_OUT = regs[sr1];
    assign SR2_OUT = regs[IR[2:0]];
    assign ALU_B   = IR[5] ? {{11{IR[4]}}, IR[4:0]} : regs[IR[2:0]];

    assign NZP = nzp_q;
    assign BEN = ben_q;

    // Exactly one code bit is produced for any BUS value.
    always_comb begin
        cc_next = 3'b001;
        if (BUS[15])
            cc_next = 3'b100;
        else if (BUS == 16'h0000)
            cc_next = 3'b010;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= 16'h0000;
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (LD_REG)
                regs[dr] <= BUS;
            if (LD_CC)
                nzp_q <= cc_next;
            // Uses nzp_q before this edge, so a simultaneous LD_CC does not feed through.
            if (LD_BEN)
                ben_q <= |(IR[11:9] & nzp_q);
        end
    end

endmodule
